// File: rtl/phantom_clock_if.sv
// Apple II ROM-socket bus as seen by the phantom clock: the chip select and
// address bits coming in, the gated ROM select and D[0] drive going out.
interface phantom_clock_if;
    logic       nRAMROMCS;
    logic [2:0] A;
    logic       RAMROMCSgb;
    logic       D0OUT;
    logic       D0OE;

    modport master (
        output nRAMROMCS,
        output A,
        input  RAMROMCSgb,
        input  D0OUT,
        input  D0OE
    );

    modport slave (
        input  nRAMROMCS,
        input  A,
        output RAMROMCSgb,
        output D0OUT,
        output D0OE
    );
endinterface

// File: rtl/phantom_clock.sv
// Phantom (no-slot) real-time clock.
//
// The clock hides behind the ROM socket. Each low pulse on nRAMROMCS is an
// access that carries one bit on A[0]. After a 64-bit recognition pattern,
// the next 64 accesses move the clock registers in or out serially, LSB of
// byte 0 first. The ROM is deselected during those 64 data accesses.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | comparing access bits against the recognition pattern
// DATA  | shifting the 64-bit time snapshot in (A[2]=0) or out (A[2]=1)
module phantom_clock #(
    parameter int PRESCALE = 71591
) (
    input  logic C7M,
    input  logic nRES,
    phantom_clock_if.slave bus
);

    localparam int             PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESCALE_LAST = PW'(PRESCALE - 1);
    // C5,3A,A3,5C twice; byte 0 sits in the low bits so pattern[cnt] is the next bit
    localparam logic [63:0]    PATTERN       = 64'h5CA3_3AC5_5CA3_3AC5;

    typedef enum logic {IDLE, DATA} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt, cnt_next;
    logic        wr, wr_next;
    logic [63:0] shadow, shadow_next;
    logic        load;

    logic        csq;
    logic        acc_start, acc_end;
    logic        lat_rd, lat_bit;
    logic        unused_a1;

    logic [PW-1:0] presc;
    logic          tick;

    logic [7:0] hund, secs, mins, hours, day, date, month, year;
    logic [7:0] last_date;
    logic [1:0] leap_sum;
    logic       leap;
    logic       c_hund, c_secs, c_mins, c_hours, c_date, c_month;
    logic [63:0] snapshot;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign unused_a1 = bus.A[1];

    assign acc_start = csq && !bus.nRAMROMCS;
    assign acc_end   = !csq && bus.nRAMROMCS;

    // Chip-select history and per-access address capture
    always_ff @(posedge C7M) begin
        if (!nRES) begin
            csq     <= 1'b1;
            lat_rd  <= 1'b0;
            lat_bit <= 1'b0;
        end else begin
            csq <= bus.nRAMROMCS;
            if (acc_start) begin
                lat_rd  <= bus.A[2];
                lat_bit <= bus.A[0];
            end
        end
    end

    // Hours read back with bit7 clear (24 h only), day with only 3 bits
    assign snapshot = {year, month, date, {5'b0, day[2:0]}, {1'b0, hours[6:0]},
                       mins, secs, hund};

    // Protocol state register
    always_ff @(posedge C7M) begin
        if (!nRES) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            wr     <= 1'b0;
            shadow <= 64'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            wr     <= wr_next;
            shadow <= shadow_next;
        end
    end

    // Pattern matching and serial transfer, evaluated only at access end
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        wr_next     = wr;
        shadow_next = shadow;
        load        = 1'b0;
        if (acc_end) begin
            case (state)
                IDLE: begin
                    if (lat_bit == PATTERN[cnt]) begin
                        if (cnt == 6'd63) begin
                            state_next  = DATA;
                            cnt_next    = 6'd0;
                            wr_next     = 1'b0;
                            shadow_next = snapshot;
                        end else begin
                            cnt_next = cnt + 6'd1;
                        end
                    end else begin
                        // no backtracking: a mismatch restarts from bit 0
                        cnt_next = 6'd0;
                    end
                end
                DATA: begin
                    if (!lat_rd) begin
                        shadow_next[cnt] = lat_bit;
                        wr_next          = 1'b1;
                    end
                    if (cnt == 6'd63) begin
                        state_next = IDLE;
                        cnt_next   = 6'd0;
                        load       = wr_next;
                    end else begin
                        cnt_next = cnt + 6'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are gated by nRES so reset takes effect before the first edge
    assign bus.D0OE       = nRES && (state == DATA) && !bus.nRAMROMCS && bus.A[2];
    assign bus.D0OUT      = shadow[cnt];
    assign bus.RAMROMCSgb = !bus.nRAMROMCS && (!nRES || state != DATA);

    assign tick = (presc == PRESCALE_LAST);

    // 1/100 s prescaler; a register load restarts the interval
    always_ff @(posedge C7M) begin
        if (!nRES)     presc <= '0;
        else if (load) presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // Leap test on the BCD year: (10*T + U) mod 4 == (2*T[0] + U[1:0]) mod 4
    assign leap_sum = {year[4], 1'b0} + year[1:0];
    assign leap     = (leap_sum == 2'b00);

    // Last date of the current month
    always_comb begin
        last_date = 8'h31;
        case (month)
            8'h02:                      last_date = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: last_date = 8'h30;
            default:                    last_date = 8'h31;
        endcase
    end

    assign c_hund  = (hund == 8'h99);
    assign c_secs  = c_hund && (secs == 8'h59);
    assign c_mins  = c_secs && (mins == 8'h59);
    assign c_hours = c_mins && (hours == 8'h23);
    assign c_date  = c_hours && (date == last_date);
    assign c_month = c_date && (month == 8'h12);

    // Live time: load from shadow wins over a coincident tick, values taken verbatim
    always_ff @(posedge C7M) begin
        if (!nRES) begin
            hund  <= 8'h00;
            secs  <= 8'h00;
            mins  <= 8'h00;
            hours <= 8'h00;
            day   <= 8'h01;
            date  <= 8'h01;
            month <= 8'h01;
            year  <= 8'h00;
        end else if (load) begin
            hund  <= shadow_next[7:0];
            secs  <= shadow_next[15:8];
            mins  <= shadow_next[23:16];
            hours <= shadow_next[31:24];
            day   <= shadow_next[39:32];
            date  <= shadow_next[47:40];
            month <= shadow_next[55:48];
            year  <= shadow_next[63:56];
        end else if (tick) begin
            hund <= c_hund ? 8'h00 : bcd_inc(hund);
            if (c_hund)  secs  <= (secs == 8'h59) ? 8'h00 : bcd_inc(secs);
            if (c_secs)  mins  <= (mins == 8'h59) ? 8'h00 : bcd_inc(mins);
            if (c_mins)  hours <= (hours == 8'h23) ? 8'h00 : bcd_inc(hours);
            if (c_hours) begin
                day  <= (day == 8'h07) ? 8'h01 : day + 8'd1;
                date <= (date == last_date) ? 8'h01 : bcd_inc(date);
            end
            if (c_date)  month <= (month == 8'h12) ? 8'h01 : bcd_inc(month);
            if (c_month) year  <= (year == 8'h99) ? 8'h00 : bcd_inc(year);
        end
    end

endmodule
